// File: rtl/sampler_pkg.sv
// Shared widths and FIFO entry layout for the sampler output path.
package sampler_pkg;

  localparam int unsigned SAMPLE_W      = 16;
  localparam int unsigned WORD_W        = 32;
  localparam int unsigned PKT_WORDS_DEF = 16;
  localparam int unsigned HALF_BIT      = 32;
  localparam int unsigned ENTRY_W       = WORD_W + 1;

  // half sits at bit HALF_BIT, above the 32-bit data word
  typedef struct packed {
    logic              half;
    logic [WORD_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous show-ahead FIFO; occupancy kept in a count register so level never
// depends on pointer difference.
module sample_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clr,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
    end
  end

  // storage is not reset; contents are only visible once counted
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/sample_packer.sv
// Pairs 16-bit compressed samples into 32-bit words, buffers them and frames
// the output stream into fixed-size packets, with flush for a short final packet.
module sample_packer
  import sampler_pkg::*;
#(
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned PKT_WORDS = PKT_WORDS_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    flush,
  input  logic [SAMPLE_W-1:0]     in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WORD_W-1:0]       out_data,
  output logic                    out_half,
  output logic                    out_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overflow,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;
  localparam int unsigned BW = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;

  logic                r_hold_v;
  logic [SAMPLE_W-1:0] r_hold;
  logic                r_push_pend;
  entry_t              r_push_entry;
  logic [BW-1:0]       r_beat;
  logic                r_flush_pend;
  logic                r_overflow;

  entry_t              w_head;
  logic [LW-1:0]       w_level;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic                w_accept;
  logic                w_xfer;
  logic                w_flush_new;
  logic                w_final;
  logic                w_drained;

  sample_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (clear),
    .i_push  (r_push_pend),
    .i_data  (r_push_entry),
    .i_pop   (w_xfer),
    .o_data  (w_head),
    .o_count (w_level),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // space check counts the word already on its way into the FIFO
  assign in_ready    = !r_flush_pend && !w_fifo_full &&
                       !(r_push_pend && (w_level == LW'(DEPTH - 1)));
  assign w_accept    = in_valid && in_ready;
  assign w_flush_new = flush && !r_flush_pend;
  assign w_drained   = w_fifo_empty && !r_hold_v && !r_push_pend;
  assign w_final     = r_flush_pend && (w_level == LW'(1)) && !r_hold_v && !r_push_pend;

  assign out_valid = !w_fifo_empty;
  assign out_data  = w_head.data;
  assign out_half  = out_valid && w_head.half;
  assign out_last  = out_valid && ((r_beat == BW'(PKT_WORDS - 1)) || w_final);
  assign w_xfer    = out_valid && out_ready;
  assign overflow  = r_overflow;
  assign level     = w_level;

  // pairing, flush tracking, packet beat and overflow; data regs need no reset
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_hold_v     <= 1'b0;
      r_push_pend  <= 1'b0;
      r_beat       <= '0;
      r_flush_pend <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_push_pend <= 1'b0;
      if (in_valid && !in_ready) r_overflow <= 1'b1;

      if (w_accept) begin
        if (r_hold_v) begin
          r_push_pend  <= 1'b1;
          r_push_entry <= '{half: 1'b0, data: {in_data, r_hold}};
          r_hold_v     <= 1'b0;
        end else if (w_flush_new) begin
          r_push_pend  <= 1'b1;
          r_push_entry <= '{half: 1'b1, data: {SAMPLE_W'(0), in_data}};
        end else begin
          r_hold   <= in_data;
          r_hold_v <= 1'b1;
        end
      end else if (w_flush_new && r_hold_v) begin
        r_push_pend  <= 1'b1;
        r_push_entry <= '{half: 1'b1, data: {SAMPLE_W'(0), r_hold}};
        r_hold_v     <= 1'b0;
      end

      if (w_flush_new) begin
        r_flush_pend <= 1'b1;
      end else if (r_flush_pend && w_drained) begin
        r_flush_pend <= 1'b0;
      end

      if (w_xfer) r_beat <= out_last ? '0 : r_beat + BW'(1);
    end
  end

endmodule

// File: doc/sample_packer.md
Name: sample_packer

Overview:
- Sits directly downstream of the sampler's compressor output.
- Accepts the 16-bit compressed sample stream, pairs half-words into 32-bit words and buffers them in a FIFO.
- Presents the words as a valid/ready stream framed into fixed-size packets (out_last) for the USB bulk IN endpoint.
- A flush request closes a short final packet when sampling stops.

Parameters:
- DEPTH, 64, FIFO depth in 32-bit words; power of two, >= 4.
- PKT_WORDS, 16, words per full packet (64 bytes); power of two, <= DEPTH.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- clear  in  1  pulse: discard all buffered data, zero counters, clear overflow
- flush  in  1  pulse: terminate the current packet after draining
- in_data  in  16  compressed sample half-word
- in_valid  in  1  in_data valid (single-cycle strobes, never held)
- in_ready  out  1  half-word can be accepted this cycle
- out_data  out  32  first-accepted half-word in [15:0], second in [31:16]
- out_half  out  1  only out_data[15:0] meaningful; [31:16] = 16'h0000
- out_last  out  1  final word of a packet
- out_valid  out  1  out_data/out_half/out_last valid
- out_ready  in  1  consumer accepts the word
- overflow  out  1  sticky: in_valid seen while in_ready low
- level  out  $clog2(DEPTH)+1  FIFO occupancy in words

Behaviour:
- Reset and clear have identical effect:
  - FIFO emptied; half-word holding register empty; beat counter 0; flush_pend 0; overflow 0.
  - Outputs: out_valid 0, out_last 0, out_half 0, level 0, in_ready 1.
  - out_data is X.
- clear has priority over flush, in_valid and out_ready in the same cycle.
- in_ready = !flush_pend && (level + push_in_flight < DEPTH). It is combinational from registers only.
- Half-word pairing:
  - First accepted half-word goes into the holding register.
  - Second accepted half-word is combined with it and pushed into the FIFO the next cycle.
- Latency: if the second half-word is accepted in cycle N and the FIFO was empty, out_valid is high in cycle N+2.
- FIFO entry is {half, data[31:0]}.
  - Read is show-ahead: out_* reflect the head entry while out_valid is high.
  - A transfer is out_valid && out_ready.
  - Simultaneous push and pop leaves level unchanged.
- Beat counter counts transfers, modulo PKT_WORDS. out_last = out_valid && (beat == PKT_WORDS-1 || final_word).
- final_word = flush_pend && level == 1 && holding empty && no push in flight.
- After a transfer with out_last, beat resets to 0.
- flush:
  - Sets flush_pend.
  - If the holding register is occupied, its half-word is pushed next cycle as {half=1, data={16'h0000, held}}.
  - flush_pend clears in the cycle after the FIFO and holding register are both empty.
  - flush with nothing buffered is a no-op: flush_pend sets and clears in the next cycle, and no word is emitted.
  - A flush while flush_pend is already set is ignored.
- overflow:
  - Set when in_valid && !in_ready; the half-word is dropped.
  - Cleared only by clear or rst.
- Output stability: once out_valid rises, out_data/out_half/out_last hold until the transfer. out_last may only rise during a hold when flush_pend has just made the word final.
- Wrap-around: read and write pointers are $clog2(DEPTH) bits and wrap naturally. level is derived from the count register, never from pointer difference.

Decomposition:
- Shared package (sampler_pkg):
  - localparams SAMPLE_W=16, WORD_W=32, default PKT_WORDS.
  - entry layout constant (HALF_BIT=32).
- One sub-module, sample_fifo: synchronous show-ahead FIFO with WIDTH and DEPTH parameters; push/pop/count/full/empty; same clk/rst.
- Pairing, flush and framing logic stays in sample_packer.

Test Plan:
- 32 half-words 16'h0000..16'h001F, out_ready=1 -> 16 words 32'h0001_0000, 32'h0003_0002, ... 32'h001F_001E; out_last only on word 16; first out_valid 2 cycles after the 2nd input.
- 3 half-words A1,B2,C3 then flush -> word 32'h00B2_00A1 (last=0), word 32'h0000_00C3 (half=1, last=1); afterwards flush_pend=0 and in_ready=1.
- out_ready=0, feed 2*DEPTH half-words -> in_ready falls when level=DEPTH; next in_valid sets overflow=1; level stays DEPTH; data drains intact and in order afterwards.
- Random out_ready stalls over 1000 half-words -> output word sequence matches a model; out_last every 16th transfer; out_data stable during stalls.
- clear asserted with level=5 and a held half-word -> next cycle level=0, out_valid=0, overflow=0, beat=0; the next full packet's out_last is on its 16th word.
- flush with empty buffer -> no out_valid for 10 cycles; in_ready low for exactly one cycle.
